// File: rtl/uart_6502.sv
// uart_6502: memory-mapped UART for the 65C02 bus (TX holding/shift, RX with receive buffer, IRQ).
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise the receive buffer is one holding register.
module uart_6502 #(
    parameter int CLK_FREQ = 1000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       r_wn,
    input  logic [1:0] A,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_n,
    input  logic       rx,
    output logic       tx
);
    localparam logic [15:0] DIV  = 16'(CLK_FREQ / BAUD);
    localparam logic [15:0] HALF = (DIV >> 1) - 16'd1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t   rx_state, rx_next;
    tx_state_t   tx_state, tx_next;
    logic        rx_s1, rx_s2, rx_s3;
    logic [15:0] rx_cnt, tx_cnt;
    logic [2:0]  rx_bit, tx_bit;
    logic [7:0]  rx_shift, tx_shift, hold, head, rd_val;
    logic        hold_full, ovr, fe, rxie, txie;
    logic        rd, wr_data, wr_stat, wr_ctrl, pop, rxa, buf_full, push_ok, ovr_set;
    logic        fall, rx_tick, tx_tick, rx_push, rx_fe, tx_load, txr;

    assign rd      = !cs_n && r_wn;
    assign wr_data = !cs_n && !r_wn && A == 2'd0;
    assign wr_stat = !cs_n && !r_wn && A == 2'd1;
    assign wr_ctrl = !cs_n && !r_wn && A == 2'd2;
    assign pop     = rd && A == 2'd0 && rxa;
    assign push_ok = rx_push && (!buf_full || pop);
    assign ovr_set = rx_push && buf_full && !pop;
    assign txr     = !hold_full;
    assign fall    = rx_s3 && !rx_s2;
    assign rx_tick = rx_cnt == 16'd0;
    assign tx_tick = tx_cnt == 16'd0;
    assign rd_val  = (A == 2'd0) ? (rxa ? head : 8'h00) :
                     (A == 2'd1) ? {4'h0, fe, ovr, txr, rxa} :
                     (A == 2'd2) ? {6'h0, txie, rxie} : 8'h00;

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo [4];
    logic [1:0] wp, rp;
    logic [2:0] cnt;

    assign rxa      = cnt != 3'd0;
    assign buf_full = cnt[2];
    assign head     = fifo[rp];

    // FIFO storage; contents are qualified by the count so no reset is needed
    always_ff @(posedge clk)
        if (push_ok) fifo[wp] <= rx_shift;

    // FIFO pointers and occupancy; push and pop may both happen in one cycle
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wp  <= 2'd0;
            rp  <= 2'd0;
            cnt <= 3'd0;
        end else begin
            wp  <= wp + 2'(push_ok);
            rp  <= rp + 2'(pop);
            cnt <= cnt + 3'(push_ok) - 3'(pop);
        end
`else
    logic [7:0] rx_hold;
    logic       rx_full;

    assign rxa      = rx_full;
    assign buf_full = rx_full;
    assign head     = rx_hold;

    // single-byte receive holding register; a push wins over a same-cycle pop
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rx_hold <= 8'h00;
            rx_full <= 1'b0;
        end else if (push_ok) begin
            rx_hold <= rx_shift;
            rx_full <= 1'b1;
        end else if (pop) begin
            rx_full <= 1'b0;
        end
`endif

    // CPU-visible registers, sticky error flags, registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ovr   <= 1'b0;
            fe    <= 1'b0;
            rxie  <= 1'b0;
            txie  <= 1'b0;
            dout  <= 8'h00;
            irq_n <= 1'b1;
        end else begin
            ovr   <= ovr_set | (ovr & ~(wr_stat & din[2]));
            fe    <= rx_fe | (fe & ~(wr_stat & din[3]));
            rxie  <= wr_ctrl ? din[0] : rxie;
            txie  <= wr_ctrl ? din[1] : txie;
            dout  <= (!cs_n && r_wn) ? rd_val : dout;
            irq_n <= ~((rxie & rxa) | (txie & txr));
        end

    // two-flop synchronizer plus a history flop for start-edge detection
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {rx_s1, rx_s2, rx_s3} <= 3'b111;
        else {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};

    // receiver state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rx_state <= RX_IDLE;
        else rx_state <= rx_next;

    // receiver next state and frame-complete strobes
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        rx_fe   = 1'b0;
        unique case (rx_state)
            RX_IDLE:  rx_next = fall ? RX_START : RX_IDLE;
            RX_START: rx_next = rx_tick ? (rx_s2 ? RX_IDLE : RX_DATA) : RX_START;
            RX_DATA:  rx_next = (rx_tick && rx_bit == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP: begin
                rx_next = rx_tick ? RX_IDLE : RX_STOP;
                rx_push = rx_tick && rx_s2;
                rx_fe   = rx_tick && !rx_s2;
            end
        endcase
    end

    // receiver bit timer, bit index and LSB-first shifter
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rx_cnt   <= HALF;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_cnt   <= (rx_state == RX_IDLE) ? HALF : rx_tick ? DIV - 16'd1 : rx_cnt - 16'd1;
            rx_bit   <= (rx_state == RX_DATA) ? rx_bit + 3'(rx_tick) : 3'd0;
            rx_shift <= (rx_state == RX_DATA && rx_tick) ? {rx_s2, rx_shift[7:1]} : rx_shift;
        end

    // transmitter state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) tx_state <= TX_IDLE;
        else tx_state <= tx_next;

    // transmitter next state; an idle transmitter takes the holding register
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_load = hold_full;
                tx_next = hold_full ? TX_START : TX_IDLE;
            end
            TX_START: tx_next = tx_tick ? TX_DATA : TX_START;
            TX_DATA:  tx_next = (tx_tick && tx_bit == 3'd7) ? TX_STOP : TX_DATA;
            TX_STOP:  tx_next = tx_tick ? TX_IDLE : TX_STOP;
        endcase
    end

    // transmitter holding register, shifter, bit timer and registered line output
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            tx_cnt    <= DIV - 16'd1;
            tx_bit    <= 3'd0;
            tx_shift  <= 8'h00;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            tx        <= 1'b1;
        end else begin
            tx_cnt    <= (tx_state == TX_IDLE || tx_tick) ? DIV - 16'd1 : tx_cnt - 16'd1;
            tx_bit    <= (tx_state == TX_DATA) ? tx_bit + 3'(tx_tick) : 3'd0;
            tx_shift  <= tx_load ? hold : (tx_state == TX_DATA && tx_tick) ? {1'b0, tx_shift[7:1]} : tx_shift;
            hold      <= (wr_data && !hold_full) ? din : hold;
            hold_full <= tx_load ? 1'b0 : (wr_data | hold_full);
            tx        <= (tx_state == TX_START) ? 1'b0 : (tx_state == TX_DATA) ? tx_shift[0] : 1'b1;
        end
endmodule

// File: tb/tb_uart_6502.sv
// tb_uart_6502: randomized self-checking bench for uart_6502 with a serial line model and a queue-based buffer model.
module tb_uart_6502;
    localparam int DIV = 4;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n, cs_n, r_wn, rx, tx, irq_n;
    logic [1:0] A;
    logic [7:0] din, dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cyc   = 0;
    logic mon_en;

    logic [7:0] rx_q[$];
    logic       m_ovr = 1'b0, m_fe = 1'b0;
    logic [7:0] tx_q[$];
    int         tx_t[$];
    logic       tx_ok[$];

    uart_6502 #(.CLK_FREQ(1000000), .BAUD(250000)) dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .r_wn(r_wn), .A(A), .din(din),
        .dout(dout), .irq_n(irq_n), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: expected STATUS from the reference buffer and flags
    function automatic logic [7:0] m_status();
        return {4'h0, m_fe, m_ovr, 1'b1, rx_q.size() != 0};
    endfunction

    function automatic logic [7:0] m_pop();
        if (rx_q.size() == 0) return 8'h00;
        return rx_q.pop_front();
    endfunction

    function automatic void m_deliver(input logic [7:0] b, input logic stop);
        if (!stop) m_fe = 1'b1;
        else if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); cs_n = 1'b0; r_wn = 1'b0; A = a; din = d;
        @(posedge clk); #1; wr_cyc = cyc; cs_n = 1'b1; r_wn = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); cs_n = 1'b0; r_wn = 1'b1; A = a;
        @(posedge clk); #1; d = dout; cs_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 200 && tx_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic get_tx(output logic [7:0] b, output logic ok, output int t);
        b = 8'h00; ok = 1'b0; t = -1;
        if (tx_q.size() > 0) begin
            b = tx_q.pop_front(); ok = tx_ok.pop_front(); t = tx_t.pop_front();
        end
    endtask

    // serial decoder: samples every cycle of a frame and requires each bit to be stable for DIV cycles
    initial begin
        int s;
        logic [39:0] smp;
        logic ok;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                s = cyc;
                smp[0] = tx;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    smp[i] = tx;
                end
                ok = (smp[0] === 1'b0) && (smp[36] === 1'b1);
                for (int k = 0; k < 10; k++)
                    for (int j = 1; j < DIV; j++)
                        if (smp[k*DIV+j] !== smp[k*DIV]) ok = 1'b0;
                for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*DIV];
                tx_q.push_back(b); tx_t.push_back(s); tx_ok.push_back(ok);
            end
        end
    end

    task automatic test_reset();
        logic [7:0] d;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL por_tx: got %b expected 1", tx); end
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL por_irq_n: got %b expected 1", irq_n); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL por_dout: got %02h expected 00", dout); end
        cpu_read(2'd1, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL por_status: got %02h expected 02", d); end
        cpu_read(2'd2, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL por_ctrl: got %02h expected 00", d); end
        cpu_write(2'd2, 8'h03);
        cpu_read(2'd2, d);
        cpu_write(2'd0, 8'h81);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (12) @(negedge clk);
                n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx: got %b expected 0", tx); end
                n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL midframe_irq_n: got %b expected 0", irq_n); end
                #2 reset_n = 1'b0;
                #1;
                n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
                n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL async_reset_irq_n: got %b expected 1", irq_n); end
                n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL async_reset_dout: got %02h expected 00", dout); end
            end
        join
        @(negedge clk); reset_n = 1'b1;
        rx_q.delete(); m_ovr = 1'b0; m_fe = 1'b0;
        repeat (5) @(negedge clk);
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL reset_status: got %02h expected %02h", d, m_status()); end
        cpu_read(2'd2, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %02h expected 00", d); end
        n_checks++; if (tx !== 1'b1 || irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_lines: got tx=%b irq_n=%b expected 1 1", tx, irq_n); end
    endtask

    task automatic test_registers();
        logic [7:0] d;
        cpu_write(2'd2, 8'hFF);
        cpu_read(2'd2, d);
        n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL ctrl_mask: got %02h expected 03", d); end
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL txie_irq: got %b expected 0", irq_n); end
        repeat (3) @(negedge clk);
        n_checks++; if (dout !== 8'h03) begin n_fail++; $display("FAIL dout_hold: got %02h expected 03", dout); end
        cpu_write(2'd2, 8'h00);
        cpu_read(2'd1, d);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_clear: got %b expected 1", irq_n); end
        cpu_read(2'd3, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reg3_read: got %02h expected 00", d); end
        cpu_write(2'd3, 8'h55);
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL reg3_write_ignored: got %02h expected %02h", d, m_status()); end
        cpu_read(2'd0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL data_empty: got %02h expected 00", d); end
    endtask

    task automatic test_transmit();
        logic [7:0] d, b;
        logic ok;
        int w, t0, t1;
        tx_q.delete(); tx_t.delete(); tx_ok.delete();
        cpu_write(2'd0, 8'hA5);
        w = wr_cyc;
        cpu_read(2'd1, d);
        n_checks++; if (d !== (m_status() & 8'hFD)) begin n_fail++; $display("FAIL txr_busy: got %02h expected %02h", d, m_status() & 8'hFD); end
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL txr_free: got %02h expected %02h", d, m_status()); end
        cpu_write(2'd0, 8'h3C);
        wait_tx(2);
        n_checks++; if (tx_q.size() != 2) begin n_fail++; $display("FAIL tx_frames: got %0d expected 2", tx_q.size()); end
        get_tx(b, ok, t0);
        n_checks++; if (b !== 8'hA5 || !ok) begin n_fail++; $display("FAIL tx_a5: got %02h ok=%b expected a5 ok=1", b, ok); end
        n_checks++; if (t0 != w + 2) begin n_fail++; $display("FAIL tx_start_latency: got %0d expected %0d", t0 - w, 2); end
        get_tx(b, ok, t1);
        n_checks++; if (b !== 8'h3C || !ok) begin n_fail++; $display("FAIL tx_3c: got %02h ok=%b expected 3c ok=1", b, ok); end
        n_checks++; if (t1 - t0 < 10*DIV || t1 - t0 > 10*DIV + 1) begin n_fail++; $display("FAIL tx_gap: got %0d expected 40..41", t1 - t0); end
    endtask

    task automatic test_tx_drop();
        logic [7:0] v[4];
        logic [7:0] b;
        logic ok;
        int t;
        for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) cpu_write(2'd0, v[i]);
        wait_tx(2);
        repeat (60) @(negedge clk);
        n_checks++; if (tx_q.size() != 2) begin n_fail++; $display("FAIL drop_count: got %0d expected 2", tx_q.size()); end
        get_tx(b, ok, t);
        n_checks++; if (b !== v[0] || !ok) begin n_fail++; $display("FAIL drop_first: got %02h ok=%b expected %02h ok=1", b, ok, v[0]); end
        get_tx(b, ok, t);
        n_checks++; if (b !== v[2] || !ok) begin n_fail++; $display("FAIL drop_third: got %02h ok=%b expected %02h ok=1", b, ok, v[2]); end
    endtask

    task automatic test_rx_irq();
        logic [7:0] d, e;
        cpu_write(2'd2, 8'h01);
        send_byte(8'h5A, 1'b1);
        m_deliver(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL rx_irq_set: got %b expected 0", irq_n); end
        e = m_pop();
        cpu_read(2'd0, d);
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL rx_data: got %02h expected %02h", d, e); end
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL rx_status_after_pop: got %02h expected %02h", d, m_status()); end
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected 1", irq_n); end
        cpu_write(2'd2, 8'h00);
    endtask

    task automatic test_overrun();
        logic [7:0] d, e;
        for (int v = 1; v <= 5; v++) begin
            send_byte(8'(v), 1'b1);
            m_deliver(8'(v), 1'b1);
        end
        repeat (3) @(negedge clk);
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL ovr_status: got %02h expected %02h", d, m_status()); end
        for (int i = 0; i < 5; i++) begin
            e = m_pop();
            cpu_read(2'd0, d);
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL ovr_read%0d: got %02h expected %02h", i, d, e); end
        end
        cpu_write(2'd1, 8'h04);
        m_ovr = 1'b0;
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL ovr_clear: got %02h expected %02h", d, m_status()); end
    endtask

    task automatic test_framing();
        logic [7:0] d;
        send_byte(8'h77, 1'b0);
        m_deliver(8'h77, 1'b0);
        repeat (3) @(negedge clk);
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL fe_status: got %02h expected %02h", d, m_status()); end
        cpu_read(2'd0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL fe_no_byte: got %02h expected 00", d); end
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (12) @(negedge clk);
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL glitch_status: got %02h expected %02h", d, m_status()); end
        cpu_write(2'd1, 8'h08);
        m_fe = 1'b0;
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL fe_clear: got %02h expected %02h", d, m_status()); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d, e, b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1);
            m_deliver(b, 1'b1);
        end
        b = 8'($urandom);
        e = m_pop();
        m_deliver(b, 1'b1);
        fork
            send_byte(b, 1'b1);
            begin
                @(negedge clk);
                repeat (10*DIV - 1) @(negedge clk);
                cpu_read(2'd0, d);
            end
        join
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL simul_head: got %02h expected %02h", d, e); end
        repeat (3) @(negedge clk);
        cpu_read(2'd1, d);
        n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL simul_status: got %02h expected %02h", d, m_status()); end
        for (int i = 0; i <= DEPTH; i++) begin
            e = m_pop();
            cpu_read(2'd0, d);
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL simul_drain%0d: got %02h expected %02h", i, d, e); end
        end
    endtask

    task automatic test_random_rx();
        logic [7:0] d, e, b;
        int k;
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                send_byte(b, 1'b1);
                m_deliver(b, 1'b1);
            end
            repeat (3) @(negedge clk);
            cpu_read(2'd1, d);
            n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL rnd_status%0d: got %02h expected %02h", it, d, m_status()); end
            for (int i = 0; i < k; i++) begin
                e = m_pop();
                cpu_read(2'd0, d);
                n_checks++; if (d !== e) begin n_fail++; $display("FAIL rnd_data%0d_%0d: got %02h expected %02h", it, i, d, e); end
            end
            cpu_write(2'd1, 8'h04);
            m_ovr = 1'b0;
            cpu_read(2'd1, d);
            n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL rnd_clear%0d: got %02h expected %02h", it, d, m_status()); end
        end
    endtask

    task automatic test_random_tx();
        logic [7:0] v, b;
        logic ok;
        int t;
        for (int it = 0; it < 4; it++) begin
            v = 8'($urandom);
            cpu_write(2'd0, v);
            wait_tx(1);
            get_tx(b, ok, t);
            n_checks++; if (b !== v || !ok) begin n_fail++; $display("FAIL rnd_tx%0d: got %02h ok=%b expected %02h ok=1", it, b, ok, v); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cs_n = 1'b1; r_wn = 1'b1; A = 2'd0; din = 8'h00; rx = 1'b1; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_registers();
        test_transmit();
        test_tx_drop();
        test_rx_irq();
        test_overrun();
        test_framing();
        test_simultaneous();
        test_random_rx();
        test_random_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
